// File: rtl/mac_pkg.sv
// Shared definitions for the 8-bit product accumulator: default widths and
// the FSM state encodings.
package mac_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int LEN_W_DEF = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

endpackage

// File: rtl/mac8_acc_sc_if.sv
// Job-control and product-stream bundle between the multiplier stage /
// controller (master) and the accumulator (slave).
interface mac8_acc_sc_if
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             clr;
  logic             prod_valid;
  logic [7:0]       prod;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic             busy;
  logic             done;
  logic             ovf;

  modport master (
    output start, len, clr, prod_valid, prod,
    input  prod_ready, acc_out, busy, done, ovf
  );

  modport slave (
    input  start, len, clr, prod_valid, prod,
    output prod_ready, acc_out, busy, done, ovf
  );

endinterface

// File: rtl/mac_acc_add.sv
// ACC_W-bit accumulate adder with carry-out. Build option MAC_ACC_SAT_EN
// clamps the sum to all-ones on carry; otherwise the sum wraps.
module mac_acc_add
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [7:0]       prod,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod};
  assign carry = full[ACC_W];

`ifdef MAC_ACC_SAT_EN
  // Once clamped, any further non-zero product carries again, so the
  // accumulator stays at all-ones for the rest of the job.
  assign sum = carry ? '1 : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac8_acc_sc.sv
// Job-based accumulator for 8-bit products from a 4x4 multiplier stage.
// Build option MAC_ACC_SAT_EN selects saturating instead of wrapping sums.
module mac8_acc_sc
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input logic          clk,
  input logic          rst_n,
  mac8_acc_sc_if.slave bus
);

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic [LEN_W-1:0] len_q;
  logic             ovf;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             accept;

  mac_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc   (acc),
    .prod  (bus.prod),
    .sum   (sum),
    .carry (carry)
  );

  assign accept  = bus.prod_valid && (state == ACCUM);
  assign cnt_nxt = cnt + LEN_W'(1);

  // clr is checked ahead of the state decode so it wins over both start
  // and a beat arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf   <= 1'b0;
    end else if (bus.clr) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            if (bus.len != '0) begin
              len_q <= bus.len;
              state <= ACCUM;
            end else begin
              state <= DONE;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= sum;
            cnt <= cnt_nxt;
            if (carry) ovf <= 1'b1;
            if (cnt_nxt == len_q) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.prod_ready = (state == ACCUM);
  assign bus.busy       = (state == ACCUM);
  assign bus.done       = (state == DONE);
  assign bus.acc_out    = acc;
  assign bus.ovf        = ovf;

endmodule

// File: tb/tb_mac8_acc_sc.sv
// Bench for mac8_acc_sc: a 16-bit and a 9-bit instance share one stimulus
// stream and are checked against a sum-based reference model.
module tb_mac8_acc_sc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac8_acc_sc_if #(.ACC_W(16), .LEN_W(8)) b16 ();
  mac8_acc_sc_if #(.ACC_W(9),  .LEN_W(8)) b9 ();

  assign b9.start      = b16.start;
  assign b9.len        = b16.len;
  assign b9.clr        = b16.clr;
  assign b9.prod_valid = b16.prod_valid;
  assign b9.prod       = b16.prod;

  mac8_acc_sc #(.ACC_W(16), .LEN_W(8)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));
  mac8_acc_sc #(.ACC_W(9),  .LEN_W(8)) u_dut9  (.clk(clk), .rst_n(rst_n), .bus(b9.slave));

  logic [19:0] o16;
  logic [12:0] o9;
  assign o16 = {b16.prod_ready, b16.busy, b16.done, b16.ovf, b16.acc_out};
  assign o9  = {b9.prod_ready,  b9.busy,  b9.done,  b9.ovf,  b9.acc_out};

  int checks   = 0;
  int failures = 0;
  logic [7:0] jp [256];

  // Accumulator value expected for a given true (unbounded) sum.
  function automatic int unsigned model_acc(int unsigned s, int unsigned w);
    int unsigned lim;
    lim = (32'd1 << w) - 32'd1;
`ifdef MAC_ACC_SAT_EN
    return (s > lim) ? lim : s;
`else
    return s & lim;
`endif
  endfunction

  function automatic logic [32:0] expv(logic rdy, logic dn, int unsigned s);
    logic [19:0] a;
    logic [12:0] b;
    a = {rdy, rdy, dn, (s > 32'd65535), 16'(model_acc(s, 16))};
    b = {rdy, rdy, dn, (s > 32'd511),   9'(model_acc(s, 9))};
    return {a, b};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one job; mode 0 = back-to-back beats, 1 = alternating valid,
  // 2 = random stalls. Products come from jp[].
  task automatic run_job(input string nm, input int unsigned n, input int unsigned mode);
    int unsigned s, na, cyc;
    logic v;
    logic [32:0] ev;
    s = 0; na = 0; cyc = 0;
    b16.start = 1'b1;
    b16.len   = 8'(n);
    tick;
    b16.start = 1'b0;
    b16.len   = 8'($urandom);
    ev = expv(n != 0, n == 0, 0);
    checks++;
    if ({o16, o9} !== ev) begin
      failures++;
      $display("FAIL %s start got=%h exp=%h", nm, {o16, o9}, ev);
    end
    while (na < n) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(9) >= 3);
      endcase
      b16.prod_valid = v;
      b16.prod       = v ? jp[na] : 8'($urandom);
      b16.start      = ($urandom_range(3) == 0);
      b16.len        = 8'($urandom_range(1, 255));
      tick;
      cyc++;
      if (v) begin
        s += jp[na];
        na++;
      end
      ev = expv(na < n, na == n, s);
      checks++;
      if ({o16, o9} !== ev) begin
        failures++;
        $display("FAIL %s beat%0d cyc%0d got=%h exp=%h", nm, na, cyc, {o16, o9}, ev);
      end
    end
    // DONE cycle: further beats and start must be ignored
    b16.prod_valid = 1'b1;
    b16.prod       = 8'hff;
    b16.start      = 1'b1;
    tick;
    b16.start      = 1'b0;
    b16.prod_valid = 1'b0;
    ev = expv(1'b0, 1'b0, s);
    checks++;
    if ({o16, o9} !== ev) begin
      failures++;
      $display("FAIL %s post_done got=%h exp=%h", nm, {o16, o9}, ev);
    end
    tick;
    checks++;
    if ({o16, o9} !== ev) begin
      failures++;
      $display("FAIL %s idle_hold got=%h exp=%h", nm, {o16, o9}, ev);
    end
  endtask

  task automatic test_reset;
    logic [32:0] ev;
    b16.start = 1'b1; b16.len = 8'd1; b16.clr = 1'b0;
    b16.prod_valid = 1'b0; b16.prod = 8'd0;
    tick;
    ev = expv(1'b0, 1'b0, 0);
    checks++;
    if ({o16, o9} !== ev) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", {o16, o9}, ev);
    end
    #3 rst_n = 1'b1;
    tick;
    b16.start = 1'b0;
    ev = expv(1'b1, 1'b0, 0);
    checks++;
    if ({o16, o9} !== ev) begin
      failures++;
      $display("FAIL first_start got=%h exp=%h", {o16, o9}, ev);
    end
    b16.prod_valid = 1'b1; b16.prod = 8'd7;
    tick;
    b16.prod_valid = 1'b0;
    ev = expv(1'b0, 1'b1, 7);
    checks++;
    if ({o16, o9} !== ev) begin
      failures++;
      $display("FAIL first_job_done got=%h exp=%h", {o16, o9}, ev);
    end
    tick;
  endtask

  task automatic test_basic;
    jp[0] = 8'd15; jp[1] = 8'd225; jp[2] = 8'd1; jp[3] = 8'd0;
    run_job("basic", 4, 0);
  endtask

  task automatic test_stall;
    jp[0] = 8'd10; jp[1] = 8'd20; jp[2] = 8'd30;
    run_job("stall", 3, 1);
  endtask

  task automatic test_zero_len;
    run_job("zero_len", 0, 0);
  endtask

  task automatic test_overflow;
    for (int unsigned i = 0; i < 3; i++) jp[i] = 8'd225;
    run_job("overflow", 3, 0);
  endtask

  task automatic test_clr;
    logic [32:0] ev;
    int unsigned s;
    // clr in IDLE wipes the sticky ovf and held result of the previous job
    b16.clr = 1'b1;
    tick;
    b16.clr = 1'b0;
    ev = expv(1'b0, 1'b0, 0);
    checks++;
    if ({o16, o9} !== ev) begin
      failures++;
      $display("FAIL clr_idle got=%h exp=%h", {o16, o9}, ev);
    end
    b16.start = 1'b1; b16.len = 8'd5;
    tick;
    b16.start = 1'b0;
    s = 0;
    for (int unsigned i = 0; i < 2; i++) begin
      b16.prod_valid = 1'b1;
      b16.prod = 8'($urandom_range(255));
      s += b16.prod;
      tick;
    end
    b16.prod_valid = 1'b0;
    b16.start = 1'b1; b16.len = 8'd1;
    tick;
    b16.start = 1'b0;
    ev = expv(1'b1, 1'b0, s);
    checks++;
    if ({o16, o9} !== ev) begin
      failures++;
      $display("FAIL start_in_accum got=%h exp=%h", {o16, o9}, ev);
    end
    b16.clr = 1'b1; b16.prod_valid = 1'b1; b16.prod = 8'd9;
    tick;
    b16.clr = 1'b0; b16.prod_valid = 1'b0;
    ev = expv(1'b0, 1'b0, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      checks++;
      if ({o16, o9} !== ev) begin
        failures++;
        $display("FAIL clr_abort c%0d got=%h exp=%h", i, {o16, o9}, ev);
      end
      tick;
    end
    b16.clr = 1'b1; b16.start = 1'b1; b16.len = 8'd3;
    tick;
    b16.clr = 1'b0; b16.start = 1'b0;
    checks++;
    if ({o16, o9} !== ev) begin
      failures++;
      $display("FAIL clr_over_start got=%h exp=%h", {o16, o9}, ev);
    end
  endtask

  task automatic test_rst_abort;
    logic [32:0] ev;
    b16.start = 1'b1; b16.len = 8'd5;
    tick;
    b16.start = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      b16.prod_valid = 1'b1; b16.prod = 8'd255;
      tick;
    end
    b16.prod_valid = 1'b1; b16.start = 1'b1; b16.len = 8'd3;
    #2 rst_n = 1'b0;
    #1;
    ev = expv(1'b0, 1'b0, 0);
    checks++;
    if ({o16, o9} !== ev) begin
      failures++;
      $display("FAIL rst_async got=%h exp=%h", {o16, o9}, ev);
    end
    tick;
    checks++;
    if ({o16, o9} !== ev) begin
      failures++;
      $display("FAIL rst_hold got=%h exp=%h", {o16, o9}, ev);
    end
    #3 rst_n = 1'b1;
    tick;
    b16.start = 1'b0; b16.prod_valid = 1'b0;
    ev = expv(1'b1, 1'b0, 0);
    checks++;
    if ({o16, o9} !== ev) begin
      failures++;
      $display("FAIL rst_release_start got=%h exp=%h", {o16, o9}, ev);
    end
    b16.clr = 1'b1;
    tick;
    b16.clr = 1'b0;
    ev = expv(1'b0, 1'b0, 0);
    checks++;
    if ({o16, o9} !== ev) begin
      failures++;
      $display("FAIL rst_then_clr got=%h exp=%h", {o16, o9}, ev);
    end
  endtask

  task automatic test_back_to_back;
    for (int unsigned j = 0; j < 2; j++) begin
      for (int unsigned i = 0; i < 6; i++) jp[i] = 8'($urandom_range(255));
      run_job("back_to_back", 6, 0);
    end
  endtask

  task automatic test_random;
    int unsigned n;
    for (int unsigned j = 0; j < 8; j++) begin
      n = $urandom_range(0, 40);
      for (int unsigned i = 0; i < n; i++) jp[i] = 8'($urandom_range(255));
      run_job("random", n, 2);
    end
    n = 255;
    for (int unsigned i = 0; i < n; i++) jp[i] = 8'd255;
    run_job("max_len", n, 2);
  endtask

  initial begin
    rst_n = 1'b0;
    b16.start = 1'b0; b16.len = '0; b16.clr = 1'b0;
    b16.prod_valid = 1'b0; b16.prod = '0;
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_overflow();
    test_clr();
    test_rst_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac8_acc_sc.md
MAC8_ACC_SC -- requirements
Module: mac8_acc_sc

Interface
REQ-001 SHALL have parameter ACC_W, 16, accumulator/result width in bits (minimum 9).
REQ-002 SHALL have parameter LEN_W, 8, width of the job-length field.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  job start pulse, honoured in IDLE only.
REQ-007 SHALL have port len  input  LEN_W  number of products in the job, sampled on an honoured start.
REQ-008 SHALL have port clr  input  1  synchronous abort.
REQ-009 SHALL have port prod_valid  input  1  upstream 4x4 multiplier product valid.
REQ-010 SHALL have port prod  input  8  unsigned 8-bit product from the 4x4 multiplier stage.
REQ-011 SHALL have port prod_ready  output  1  block accepts a product this cycle.
REQ-012 SHALL have port acc_out  output  ACC_W  accumulated result.
REQ-013 SHALL have port busy  output  1  job in progress (ACCUM state).
REQ-014 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-015 SHALL have port ovf  output  1  sticky per-job overflow flag.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-017 In IDLE, start=1 with len!=0: clear accumulator, count and ovf, latch len, and enter ACCUM next cycle.
REQ-018 In IDLE, start=1 with len==0: clear accumulator and ovf, then go directly to DONE.
REQ-019 prod_ready SHALL be 1 exactly when state==ACCUM; busy SHALL equal prod_ready.
REQ-020 A beat is accepted only when prod_valid & prod_ready: acc <= acc + zero-extended prod, and count increments.
REQ-021 The accept that makes count equal the latched len SHALL move the FSM to DONE; no further beats are accepted.
REQ-022 In ACCUM, cycles with prod_valid=0 are stalls: acc and count are held.
REQ-023 done SHALL be 1 for exactly the single DONE cycle, which is the cycle after the last accept; the FSM then returns to IDLE.
REQ-024 acc_out SHALL show the running accumulator and hold the final value from DONE until the next honoured start.
REQ-025 start SHALL be ignored in ACCUM and DONE.
REQ-026 ovf SHALL set when the true sum exceeds 2^ACC_W-1 and hold until the next honoured start.
REQ-027 clr=1 in any state: next state IDLE, acc, count and ovf cleared, no done pulse; clr SHALL take priority over start and over beat acceptance.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, acc_out=0, count=0, ovf=0, done=0, busy=0 and prod_ready=0, including mid-job.
REQ-029 The first honoured start SHALL be the first rising edge with rst_n=1.

Configuration
REQ-030 Macro MAC_ACC_SAT_EN defined: on overflow, acc SHALL clamp to all-ones and stay there for the rest of the job.
REQ-031 Macro MAC_ACC_SAT_EN undefined: acc SHALL wrap modulo 2^ACC_W; ovf SHALL behave identically in both builds.

Structure
REQ-032 Shared package mac_pkg SHALL hold the FSM state encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and the default ACC_W and LEN_W values.
REQ-033 Sub-module mac_acc_add SHALL hold the ACC_W-bit adder, which produces the carry-out used for ovf and applies saturation under MAC_ACC_SAT_EN.

Verification
REQ-034 Test 1: len=4, products 15,225,1,0 back-to-back -> acc_out=241, done pulses one cycle after the 4th accept, ovf=0.
REQ-035 Test 2: len=3, prod_valid toggling 1,0,1,0,1 with products 10,20,30 -> acc_out=60, exactly 3 accepts, single done pulse.
REQ-036 Test 3: ACC_W=9, len=3, products 225x3 -> ovf=1; acc_out=511 with MAC_ACC_SAT_EN, 163 without it.
REQ-037 Test 4: start with len=0 -> done on the 2nd cycle after start, acc_out=0, prod_ready never asserted.
REQ-038 Test 5: clr, and separately rst_n low, after 2 of 5 beats -> IDLE, acc_out=0, no done; start pulsed during ACCUM is ignored.
